// File: rtl/quant_pkg.sv
// Shared types and tables for the quantizer controller.
// Contents: JPEG luma Q table (raster order), zigzag scan order, FSM state encoding.
package quant_pkg;

    localparam int COEF_W = 11;
    localparam int QDIV_W = 7;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {IDLE, DIV, OUT, DRAIN} qstate_t;

    localparam logic [QDIV_W-1:0] LUMA_Q [64] = '{
        7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61,
        7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55,
        7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56,
        7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62,
        7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77,
        7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92,
        7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
        7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99
    };

    // Zigzag position -> raster index.
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/quant_div_seq.sv
// Unsigned restoring divider: loads on start, one quotient bit per cycle for DATA_W cycles,
// then pulses done for one cycle with the quotient held until the next start.
module quant_div_seq #(
    parameter int DATA_W = 11,
    parameter int DIV_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DIV_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] dsr;
    logic [DIV_W:0]   shifted;
    logic [DIV_W-1:0] diff;

    // The quotient register doubles as the dividend shift register.
    assign shifted = {rem, quotient[DATA_W-1]};
    assign diff    = shifted[DIV_W-1:0] - dsr;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            dsr      <= '0;
            quotient <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient <= dividend;
                dsr      <= divisor;
                rem      <= '0;
                cnt      <= CNT_W'(DATA_W);
                busy     <= 1'b1;
            end else if (busy) begin
                if (shifted >= {1'b0, dsr}) begin
                    rem      <= diff;
                    quotient <= {quotient[DATA_W-2:0], 1'b1};
                end else begin
                    rem      <= shifted[DIV_W-1:0];
                    quotient <= {quotient[DATA_W-2:0], 1'b0};
                end
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/quant_block_ctrl.sv
// Quantizer controller: accepts one coefficient per handshake, divides by the luma Q entry with a shared
// serial divider and streams the result. Define ZIGZAG_OUT_EN to buffer a block and drain it in zigzag order.
module quant_block_ctrl
    import quant_pkg::*;
#(
    parameter int DATA_W = COEF_W,
    parameter int DIV_W  = QDIV_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_last,
    output logic [5:0]               m_idx,
    output logic                     err
);
    qstate_t                  state, state_nxt;
    logic                     started, accept, framing_bad, neg;
    logic [5:0]               idx, cur_idx;
    logic [DATA_W-1:0]        mag, div_quo;
    logic [DIV_W-1:0]         divisor;
    logic                     div_busy, div_done;
    logic signed [DATA_W-1:0] result;
`ifdef ZIGZAG_OUT_EN
    logic signed [DATA_W-1:0] blk_mem [64];
    logic [63:0]              written;
    logic [5:0]               zz, zz_raw;
    logic                     blk_end;
`endif

    assign accept      = s_valid && s_ready;
    assign framing_bad = s_last != (idx == 6'd63);
    assign mag         = s_data[DATA_W-1] ? -s_data : s_data;
    assign divisor     = DIV_W'(LUMA_Q[idx]);
    assign result      = neg ? -$signed(div_quo) : $signed(div_quo);

    quant_div_seq #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && !div_busy),
        .dividend (mag),
        .divisor  (divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    // started keeps s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; a missing branch would otherwise infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = DIV;
            DIV: begin
                if (div_done) begin
`ifdef ZIGZAG_OUT_EN
                    state_nxt = blk_end ? DRAIN : IDLE;
`else
                    state_nxt = OUT;
`endif
                end
            end
            OUT: if (m_ready) state_nxt = IDLE;
            DRAIN: begin
`ifdef ZIGZAG_OUT_EN
                if (m_ready && zz == 6'd63) state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_ready = started && (state == IDLE);
    assign m_valid = (state == OUT) || (state == DRAIN);
    assign m_last  = m_valid && (m_idx == 6'd63);

    // A framing error still lets the current coefficient finish; only the index restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            cur_idx <= '0;
            neg     <= 1'b0;
            err     <= 1'b0;
        end else if (accept) begin
            cur_idx <= idx;
            neg     <= s_data[DATA_W-1];
            if (framing_bad) begin
                err <= 1'b1;
                idx <= '0;
            end else begin
                idx <= idx + 6'd1;
            end
        end
    end

`ifdef ZIGZAG_OUT_EN
    assign zz_raw = ZIGZAG[zz];

    // NOTE: the buffer has no reset; the written mask decides which entries belong to the current block.
    always_ff @(posedge clk) begin
        if (state == DIV && div_done) blk_mem[cur_idx] <= result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
            zz      <= '0;
            blk_end <= 1'b0;
        end else begin
            if (accept) blk_end <= s_last || (idx == 6'd63);
            if (state == DIV && div_done) written[cur_idx] <= 1'b1;
            if (state == DRAIN && m_ready) begin
                zz <= zz + 6'd1;
                if (zz == 6'd63) written <= '0;
            end
        end
    end

    assign m_idx  = (state == DRAIN) ? zz_raw : '0;
    assign m_data = (state == DRAIN && written[zz_raw]) ? blk_mem[zz_raw] : '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= '0;
            m_idx  <= '0;
        end else if (state == DIV && div_done) begin
            m_data <= result;
            m_idx  <= cur_idx;
        end
    end
`endif

endmodule

// File: tb/tb_quant_block_ctrl.sv
// Self-checking bench for quant_block_ctrl: vector table, hand sequences for stalls, framing and reset,
// and a randomized phase checked against a truncating-division reference model.
module tb_quant_block_ctrl;
    localparam int DATA_W = quant_pkg::COEF_W;
    localparam int BOUND  = 200;

    typedef struct {
        int data;
        bit last;
        int exp_data;
        int exp_idx;
        bit exp_last;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
    logic s_ready, m_valid, m_last, err;
    quant_pkg::coef_t s_data = '0;
    quant_pkg::coef_t m_data;
    logic [5:0] m_idx;

    int checks = 0, errors = 0;
    int model_idx = 0;
    bit model_err = 1'b0;
    int zz_tab[64];
    vec_t vecs[64];
    int q_tab[64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    always #5 clk = ~clk;

    quant_block_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_idx   (m_idx),
        .err     (err)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SV integer division truncates toward zero, which is exactly the quantizer rule.
    function automatic int quant(input int x, input int r);
        return x / q_tab[r];
    endfunction

    function automatic int rand_coef();
        return int'($urandom_range(2047, 0)) - 1024;
    endfunction

    function automatic int model_accept(input bit last);
        int cur = model_idx;
        if (last != (cur == 63)) begin
            model_err = 1'b1;
            model_idx = 0;
        end else begin
            model_idx = (cur + 1) % 64;
        end
        return cur;
    endfunction

    task automatic send(input int x, input bit last);
        int n = 0;
        s_data  = DATA_W'(x);
        s_last  = last;
        s_valid = 1'b1;
        while (!s_ready && n < BOUND) begin
            tick();
            n++;
        end
        if (!s_ready) check("s_ready_wait", int'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic recv(output int d, output int i, output int l, output int lat);
        lat = 0;
        while (!m_valid && lat < BOUND) begin
            tick();
            lat++;
        end
        d = m_data;
        i = m_idx;
        l = m_last;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input int x, input bit last, input int exp_d,
                           input int exp_i, input bit exp_err);
        int d, i, l, lat;
        send(x, last);
        recv(d, i, l, lat);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_idx"}, i, exp_i);
        check({tag, "_last"}, l, int'(exp_i == 63));
        check({tag, "_lat"}, lat, DATA_W + 1);
        check({tag, "_err"}, int'(err), int'(exp_err));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!m_valid && n < BOUND) begin
            tick();
            n++;
        end
        if (!m_valid) check({tag, "_valid_wait"}, int'(m_valid), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, i, l, lat, x, r, vcount, k2;
        bit last;
        int pv[3];

        k2 = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int row = (s < 7 ? s : 7); row >= (s > 7 ? s - 7 : 0); row--) begin
                    zz_tab[k2] = row * 8 + (s - row);
                    k2++;
                end
            end else begin
                for (int row = (s > 7 ? s - 7 : 0); row <= (s < 7 ? s : 7); row++) begin
                    zz_tab[k2] = row * 8 + (s - row);
                    k2++;
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_m_idx", int'(m_idx), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        #1;
        check("s_ready_before_edge", int'(s_ready), 0);
        tick();
        check("s_ready_after_edge", int'(s_ready), 1);

`ifdef ZIGZAG_OUT_EN
        for (int k = 0; k < 64; k++) send(k * 16, k == 63);
        for (int e = 0; e < 64; e++) begin
            wait_valid("zz");
            r = zz_tab[e];
            check($sformatf("zz%0d_idx", e), int'(m_idx), r);
            check($sformatf("zz%0d_data", e), int'(m_data), quant(r * 16, r));
            check($sformatf("zz%0d_last", e), int'(m_last), int'(e == 63));
            check($sformatf("zz%0d_s_ready", e), int'(s_ready), 0);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        check("zz_end_valid", int'(m_valid), 0);
        check("zz_end_s_ready", int'(s_ready), 1);
        check("zz_end_err", int'(err), 0);

        pv[0] = -500;
        pv[1] = 200;
        pv[2] = -50;
        for (int k = 0; k < 3; k++) send(pv[k], k == 2);
        for (int e = 0; e < 64; e++) begin
            wait_valid("part");
            r = zz_tab[e];
            check($sformatf("part%0d_idx", e), int'(m_idx), r);
            check($sformatf("part%0d_data", e), int'(m_data), (r < 3) ? quant(pv[r], r) : 0);
            check($sformatf("part%0d_last", e), int'(m_last), int'(e == 63));
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        check("part_end_valid", int'(m_valid), 0);
        check("part_err", int'(err), 1);
`else
        vecs[0] = '{100, 1'b0, 6, 0, 1'b0};
        vecs[1] = '{-100, 1'b0, -9, 1, 1'b0};
        vecs[2] = '{-1024, 1'b0, -102, 2, 1'b0};
        for (int k = 3; k < 63; k++) begin
            x = rand_coef();
            vecs[k] = '{x, 1'b0, quant(x, k), k, 1'b0};
        end
        vecs[63] = '{1023, 1'b1, 10, 63, 1'b1};

        for (int k = 0; k < 64; k++) begin
            send(vecs[k].data, vecs[k].last);
            recv(d, i, l, lat);
            check($sformatf("vec%0d_data", k), d, vecs[k].exp_data);
            check($sformatf("vec%0d_idx", k), i, vecs[k].exp_idx);
            check($sformatf("vec%0d_last", k), l, int'(vecs[k].exp_last));
            check($sformatf("vec%0d_lat", k), lat, DATA_W + 1);
        end
        check("block_err", int'(err), 0);

        // Back-pressure: output must hold for 20 stalled cycles, then hand over exactly once.
        r = model_accept(1'b0);
        send(500, 1'b0);
        wait_valid("stall");
        for (int k = 0; k < 20; k++) begin
            check("stall_data", int'(m_data), 31);
            check("stall_idx", int'(m_idx), r);
            check("stall_valid", int'(m_valid), 1);
            check("stall_s_ready", int'(s_ready), 0);
            tick();
        end
        m_ready = 1'b1;
        tick();
        check("release_valid", int'(m_valid), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_dup_valid", int'(m_valid), 0);
        end
        m_ready = 1'b0;

        // Early s_last on the 10th coefficient of the block.
        for (int k = 1; k <= 9; k++) begin
            x = rand_coef();
            last = (k == 9);
            r = model_accept(last);
            run_one($sformatf("frame%0d", k), x, last, quant(x, r), r, model_err);
        end
        void'(model_accept(1'b0));
        run_one("after_frame", 160, 1'b0, 10, 0, 1'b1);
        x = rand_coef();
        r = model_accept(1'b0);
        run_one("after_frame2", x, 1'b0, quant(x, r), r, model_err);

        // Reset in the middle of a divide.
        send(300, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_s_ready", int'(s_ready), 0);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_m_data", int'(m_data), 0);
        check("midrst_m_idx", int'(m_idx), 0);
        check("midrst_m_last", int'(m_last), 0);
        check("midrst_err", int'(err), 0);
        tick();
        tick();
        rst_n = 1'b1;
        model_idx = 0;
        model_err = 1'b0;
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (m_valid) vcount++;
        end
        check("no_stale_output", vcount, 0);
        void'(model_accept(1'b0));
        run_one("post_rst", 100, 1'b0, 6, 0, 1'b0);

        // Randomized traffic against the reference model, including a wrap past index 63.
        for (int k = 0; k < 70; k++) begin
            x = rand_coef();
            last = (model_idx == 63) ? ($urandom_range(3, 0) != 0) : ($urandom_range(24, 0) == 0);
            r = model_accept(last);
            run_one($sformatf("rnd%0d", k), x, last, quant(x, r), r, model_err);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
